rename_core: RTL and testbench

- Register-rename and physical-register-storage block for the R10K-style out-of-order core.
- Combines three pieces:
  - Map table: architectural to physical tag, plus a ready bit.
  - Free list: circular FIFO of unallocated physical tags.
  - Physical register file (PRF): values, with write-to-read bypass.
- Dispatch/decode uses it for rename; issue uses it for operand reads; execute/complete uses it for writeback and CDB wakeup; retire uses it to return old tags.

---
 rtl/rename_core.sv | 122 ++++++++++++
 tb/tb_rename_core.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_core.sv
// Register rename block: arch->phys map table with ready bits, circular free list
// of physical tags, and a physical register file with write-to-read bypass.
module rename_core #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int XLEN     = 32,
  localparam int TAG_W    = $clog2(NUM_PHYS),
  localparam int AREG_W   = $clog2(NUM_ARCH),
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH,
  localparam int FL_PTR_W = $clog2(FL_DEPTH),
  localparam int CNT_W    = $clog2(FL_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [AREG_W-1:0] dispatch_rd,
  input  logic [AREG_W-1:0] dispatch_rs1,
  input  logic [AREG_W-1:0] dispatch_rs2,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic              rs1_ready,
  output logic [TAG_W-1:0]  rs2_tag,
  output logic              rs2_ready,
  output logic [TAG_W-1:0]  new_tag,
  output logic [TAG_W-1:0]  old_tag,
  output logic              free_avail,
  input  logic              cdb_en,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [TAG_W-1:0]  rd1_tag,
  input  logic [TAG_W-1:0]  rd2_tag,
  output logic [XLEN-1:0]   rd1_data,
  output logic [XLEN-1:0]   rd2_data,
  input  logic              retire_en,
  input  logic [TAG_W-1:0]  retire_told
);

  logic [TAG_W-1:0]    map_tag   [NUM_ARCH];
  logic                map_rdy   [NUM_ARCH];
  logic [TAG_W-1:0]    free_list [FL_DEPTH];
  logic [XLEN-1:0]     prf       [NUM_PHYS];
  logic [FL_PTR_W-1:0] head;
  logic [FL_PTR_W-1:0] tail;
  logic [CNT_W-1:0]    count;

  logic alloc;
  logic push;
  logic prf_we;

  function automatic logic [FL_PTR_W-1:0] ptr_inc(input logic [FL_PTR_W-1:0] p);
    return (p == FL_PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] prf_read(input logic [TAG_W-1:0] tag);
    if (tag == '0)                 return '0;
    else if (prf_we && tag == wr_tag) return wr_data;
    else                           return prf[tag];
  endfunction

  assign free_avail = (count != '0);
  assign alloc      = dispatch_en && free_avail && (dispatch_rd != '0);
  assign push       = retire_en && (retire_told != '0) && (count != CNT_W'(FL_DEPTH));
  assign prf_we     = wr_en && (wr_tag != '0);

  // Lookups see the pre-update mapping; a same-cycle CDB hit forwards readiness.
  assign rs1_tag   = map_tag[dispatch_rs1];
  assign rs2_tag   = map_tag[dispatch_rs2];
  assign rs1_ready = map_rdy[dispatch_rs1] || (cdb_en && cdb_tag == map_tag[dispatch_rs1]);
  assign rs2_ready = map_rdy[dispatch_rs2] || (cdb_en && cdb_tag == map_tag[dispatch_rs2]);
  assign old_tag   = map_tag[dispatch_rd];
  assign new_tag   = (dispatch_rd == '0) ? '0 : free_list[head];

  assign rd1_data = prf_read(rd1_tag);
  assign rd2_data = prf_read(rd2_tag);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        map_tag[i] <= TAG_W'(i);
        map_rdy[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        if (cdb_en && map_tag[i] == cdb_tag) map_rdy[i] <= 1'b1;
      end
      // NOTE: with non-blocking assignments the last write in the block wins, so
      // placing the allocation after the CDB wakeup gives allocation priority.
      if (alloc) begin
        map_tag[dispatch_rd] <= free_list[head];
        map_rdy[dispatch_rd] <= 1'b0;
      end
    end
  end

  // NOTE: these storage arrays are reset on purpose; the free list must start
  // holding the upper tags and the PRF must read back zero after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) free_list[i] <= TAG_W'(NUM_ARCH + i);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_DEPTH);
    end else begin
      if (alloc) head <= ptr_inc(head);
      if (push) begin
        free_list[tail] <= retire_told;
        tail            <= ptr_inc(tail);
      end
      count <= count + CNT_W'(push) - CNT_W'(alloc);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS; i++) prf[i] <= '0;
    end else if (prf_we) begin
      prf[wr_tag] <= wr_data;
    end
  end

endmodule

// File: tb/tb_rename_core.sv
// Scoreboard bench for rename_core: expectations are queued when stimulus is driven
// and compared against the combinational outputs on the following falling edge.
module tb_rename_core;

  logic        clock;
  logic        reset;
  logic        dispatch_en;
  logic [4:0]  dispatch_rd, dispatch_rs1, dispatch_rs2;
  logic [5:0]  rs1_tag, rs2_tag, new_tag, old_tag;
  logic        rs1_ready, rs2_ready, free_avail;
  logic        cdb_en;
  logic [5:0]  cdb_tag;
  logic        wr_en;
  logic [5:0]  wr_tag, rd1_tag, rd2_tag;
  logic [31:0] wr_data, rd1_data, rd2_data;
  logic        retire_en;
  logic [5:0]  retire_told;

  rename_core dut (
    .clock(clock), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_rd(dispatch_rd),
    .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2),
    .rs1_tag(rs1_tag), .rs1_ready(rs1_ready), .rs2_tag(rs2_tag), .rs2_ready(rs2_ready),
    .new_tag(new_tag), .old_tag(old_tag), .free_avail(free_avail),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag),
    .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data),
    .rd1_tag(rd1_tag), .rd2_tag(rd2_tag), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .retire_en(retire_en), .retire_told(retire_told)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum {O_RS1_TAG, O_RS1_RDY, O_RS2_TAG, O_RS2_RDY, O_NEW, O_OLD,
                O_AVAIL, O_RD1, O_RD2} out_e;
  typedef struct {
    string       name;
    out_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int          m_tag [32];
  bit          m_rdy [32];
  int          m_fl  [32];
  int          m_hd, m_tl, m_cnt;
  logic [31:0] m_prf [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input out_e s);
    case (s)
      O_RS1_TAG: return {26'd0, rs1_tag};
      O_RS1_RDY: return {31'd0, rs1_ready};
      O_RS2_TAG: return {26'd0, rs2_tag};
      O_RS2_RDY: return {31'd0, rs2_ready};
      O_NEW:     return {26'd0, new_tag};
      O_OLD:     return {26'd0, old_tag};
      O_AVAIL:   return {31'd0, free_avail};
      O_RD1:     return rd1_data;
      default:   return rd2_data;
    endcase
  endfunction

  task automatic push1(input string name, input out_e sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  function automatic bit m_ready(input int a);
    if (a == 0) return 1'b1;
    return m_rdy[a] || (cdb_en && int'(cdb_tag) == m_tag[a]);
  endfunction

  function automatic logic [31:0] m_read(input int t);
    if (t == 0) return 32'd0;
    if (wr_en && wr_tag != 0 && int'(wr_tag) == t) return wr_data;
    return m_prf[t];
  endfunction

  // Queue model predictions for every output under the currently driven inputs.
  task automatic push_all();
    push1("rs1_tag", O_RS1_TAG, (dispatch_rs1 == 0) ? 32'd0 : 32'(m_tag[dispatch_rs1]));
    push1("rs1_ready", O_RS1_RDY, {31'd0, m_ready(int'(dispatch_rs1))});
    push1("rs2_tag", O_RS2_TAG, (dispatch_rs2 == 0) ? 32'd0 : 32'(m_tag[dispatch_rs2]));
    push1("rs2_ready", O_RS2_RDY, {31'd0, m_ready(int'(dispatch_rs2))});
    push1("new_tag", O_NEW, (dispatch_rd == 0) ? 32'd0 : 32'(m_fl[m_hd]));
    push1("old_tag", O_OLD, (dispatch_rd == 0) ? 32'd0 : 32'(m_tag[dispatch_rd]));
    push1("free_avail", O_AVAIL, (m_cnt != 0) ? 32'd1 : 32'd0);
    push1("rd1_data", O_RD1, m_read(int'(rd1_tag)));
    push1("rd2_data", O_RD2, m_read(int'(rd2_tag)));
  endtask

  task automatic model_update();
    bit al, rt;
    int head_tag;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_tag[i] = i;
        m_rdy[i] = 1'b1;
        m_fl[i]  = 32 + i;
      end
      for (int i = 0; i < 64; i++) m_prf[i] = 32'd0;
      m_hd = 0; m_tl = 0; m_cnt = 32;
    end else begin
      al = dispatch_en && (m_cnt != 0) && (dispatch_rd != 0);
      rt = retire_en && (retire_told != 0) && (m_cnt < 32);
      head_tag = m_fl[m_hd];
      if (cdb_en)
        for (int i = 0; i < 32; i++) if (m_tag[i] == int'(cdb_tag)) m_rdy[i] = 1'b1;
      if (al) begin
        m_tag[dispatch_rd] = head_tag;
        m_rdy[dispatch_rd] = 1'b0;
        m_hd  = (m_hd + 1) % 32;
        m_cnt = m_cnt - 1;
      end
      if (rt) begin
        m_fl[m_tl] = int'(retire_told);
        m_tl  = (m_tl + 1) % 32;
        m_cnt = m_cnt + 1;
      end
      if (wr_en && wr_tag != 0) m_prf[wr_tag] = wr_data;
    end
  endtask

  // Compare queued expectations at the falling edge, advance the model, cross the edge.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, observe(e.sel), e.exp);
    end
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; dispatch_en = 0; dispatch_rd = 0; dispatch_rs1 = 0; dispatch_rs2 = 0;
    cdb_en = 0; cdb_tag = 0; wr_en = 0; wr_tag = 0; wr_data = 0;
    rd1_tag = 0; rd2_tag = 0; retire_en = 0; retire_told = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset state and first rename; rs1==rd sees the old mapping
    dispatch_en = 1; dispatch_rd = 3; dispatch_rs1 = 3; dispatch_rs2 = 0;
    push1("tp1_rs1_tag", O_RS1_TAG, 3);
    push1("tp1_rs1_ready", O_RS1_RDY, 1);
    push1("tp1_rs2_tag", O_RS2_TAG, 0);
    push1("tp1_rs2_ready", O_RS2_RDY, 1);
    push1("tp1_new_tag", O_NEW, 32);
    push1("tp1_old_tag", O_OLD, 3);
    push1("tp1_free_avail", O_AVAIL, 1);
    push_all();
    tick();
    push1("tp2_rs1_tag", O_RS1_TAG, 32);
    push1("tp2_rs1_ready", O_RS1_RDY, 0);
    push1("tp2_new_tag", O_NEW, 33);
    push1("tp2_old_tag", O_OLD, 32);
    push_all();
    tick();

    // CDB forwarding same cycle, then registered ready
    dispatch_en = 0; cdb_en = 1; cdb_tag = 33;
    push1("cdb_fwd_ready", O_RS1_RDY, 1);
    push_all();
    tick();
    cdb_en = 0;
    push1("cdb_reg_ready", O_RS1_RDY, 1);
    push_all();
    tick();

    // Allocation beats a same-cycle CDB wakeup on the same entry
    dispatch_en = 1;
    push_all();
    tick();
    cdb_en = 1; cdb_tag = 6'(m_tag[3]);
    push_all();
    tick();
    dispatch_en = 0; cdb_en = 0;
    push1("alloc_beats_cdb_tag", O_RS1_TAG, 35);
    push1("alloc_beats_cdb_ready", O_RS1_RDY, 0);
    push_all();
    tick();

    // PRF write bypass, held value, tag 0 reads zero
    wr_en = 1; wr_tag = 32; wr_data = 1; rd1_tag = 32;
    push1("prf_bypass", O_RD1, 1);
    push_all();
    tick();
    wr_en = 0;
    push1("prf_held", O_RD1, 1);
    push_all();
    tick();
    wr_en = 1; wr_tag = 0; wr_data = 5; rd1_tag = 0;
    push1("prf_tag0_bypass", O_RD1, 0);
    push_all();
    tick();
    wr_en = 0;
    push1("prf_tag0_after", O_RD1, 0);
    push_all();
    tick();

    // Exhaust the free list on rd=3, then refill with one retire
    do_reset();
    dispatch_en = 1; dispatch_rd = 3; dispatch_rs1 = 3;
    for (int i = 0; i < 32; i++) begin
      push1($sformatf("drain_new_tag_%0d", i), O_NEW, 32'(32 + i));
      push_all();
      tick();
    end
    push1("drain_empty", O_AVAIL, 0);
    push_all();
    tick();
    dispatch_en = 0; retire_en = 1; retire_told = 3;
    push1("drain_stall_old_tag", O_OLD, 63);
    push_all();
    tick();
    retire_en = 0;
    push1("refill_avail", O_AVAIL, 1);
    push1("refill_new_tag", O_NEW, 3);
    push_all();
    tick();

    // Get to count=1 with tag 40 at head, then allocate and retire together
    dispatch_en = 1;
    push_all();
    tick();
    dispatch_en = 0; retire_en = 1; retire_told = 40;
    push_all();
    tick();
    dispatch_en = 1; retire_told = 5;
    push1("alloc_ret_head", O_NEW, 40);
    push_all();
    tick();
    dispatch_en = 0; retire_en = 0;
    push1("alloc_ret_new_tag", O_NEW, 5);
    push1("alloc_ret_avail", O_AVAIL, 1);
    push_all();
    tick();
    dispatch_en = 1;
    push_all();
    tick();
    dispatch_en = 0;
    push1("alloc_ret_count1", O_AVAIL, 0);
    push_all();
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      dispatch_en  = ($urandom_range(0, 3) != 0);
      dispatch_rd  = 5'($urandom_range(0, 31));
      dispatch_rs1 = 5'($urandom_range(0, 31));
      dispatch_rs2 = 5'($urandom_range(0, 31));
      cdb_en       = $urandom_range(0, 1) == 1;
      cdb_tag      = 6'($urandom_range(0, 63));
      wr_en        = $urandom_range(0, 1) == 1;
      wr_tag       = 6'($urandom_range(0, 63));
      wr_data      = $urandom;
      rd1_tag      = ($urandom_range(0, 3) == 0) ? wr_tag : 6'($urandom_range(0, 63));
      rd2_tag      = 6'($urandom_range(0, 63));
      retire_en    = ($urandom_range(0, 2) != 0);
      retire_told  = 6'($urandom_range(0, 63));
      push_all();
      tick();
    end

    // Reset mid-sequence overrides same-cycle requests
    do_reset();
    wr_en = 1; wr_tag = 32; wr_data = 32'hdead_beef;
    tick();
    wr_en = 0; dispatch_en = 1; dispatch_rd = 3; dispatch_rs1 = 3; rd1_tag = 32;
    for (int i = 0; i < 10; i++) begin
      push_all();
      tick();
    end
    reset = 1; wr_en = 1; wr_tag = 32; wr_data = 32'h55;
    push_all();
    tick();
    reset = 0; wr_en = 0; dispatch_en = 0;
    push1("rst_map3_tag", O_RS1_TAG, 3);
    push1("rst_map3_ready", O_RS1_RDY, 1);
    push1("rst_new_tag", O_NEW, 32);
    push1("rst_prf32", O_RD1, 0);
    push1("rst_avail", O_AVAIL, 1);
    push_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
